// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word peripheral.
// Mode encodings and byte ordering helper.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Word byte slot carrying the n-th byte on the wire.
  function automatic int byte_index(
    input int n,
    input bit lsb_first,
    input int bpw
  );
    return lsb_first ? n : bpw - 1 - n;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser for SCK/CS/COPI.
// Emits registered 1-clk edge pulses in the clk domain.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 3,
  parameter bit CPOL        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs,
  input  logic copi,
  output logic sck_lead,
  output logic sck_trail,
  output logic cs_active,
  output logic cs_rise,
  output logic cs_fall,
  output logic copi_s
);

  localparam int N = SYNC_STAGES;

  logic [N-1:0] sck_q;
  logic [N-1:0] cs_q;
  logic [N-1:0] copi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q     <= {N{CPOL}};
      cs_q      <= '1;
      copi_q    <= '0;
      sck_lead  <= 1'b0;
      sck_trail <= 1'b0;
      cs_active <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      copi_s    <= 1'b0;
    end else begin
      sck_q     <= {sck_q[N-2:0], sck};
      cs_q      <= {cs_q[N-2:0], cs};
      copi_q    <= {copi_q[N-2:0], copi};
      sck_lead  <= (sck_q[N-2] != CPOL) &&
                   (sck_q[N-1] == CPOL);
      sck_trail <= (sck_q[N-2] == CPOL) &&
                   (sck_q[N-1] != CPOL);
      cs_active <= !cs_q[N-2];
      cs_rise   <= cs_q[N-2] && !cs_q[N-1];
      cs_fall   <= !cs_q[N-2] && cs_q[N-1];
      copi_s    <= copi_q[N-2];
    end
  end

endmodule

// File: rtl/spi_word_peripheral.sv
// SPI peripheral moving W-bit words, any CPOL/CPHA.
// RX handshake with overrun, abort reporting, TX load strobe.
module spi_word_peripheral
  import spi_pkg::*;
#(
  parameter int BYTES_PER_WORD = 8,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int LSB_BYTE_FIRST = 1,
  parameter int SYNC_STAGES    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        SCK,
  input  logic                        CS,
  input  logic                        COPI,
  output wire                         CIPO,
  input  logic [8*BYTES_PER_WORD-1:0] tx_word,
  output logic                        tx_load,
  output logic [8*BYTES_PER_WORD-1:0] rx_word,
  output logic                        rx_valid,
  input  logic                        rx_ack,
  output logic                        rx_overrun,
  output logic                        frame_abort
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(W);
  localparam logic [1:0] MODE = {1'(CPOL), 1'(CPHA)};
  localparam bit SAMPLE_TRAIL =
    (MODE == MODE1) || (MODE == MODE3);

  logic sck_lead;
  logic sck_trail;
  logic cs_active;
  logic cs_rise;
  logic cs_fall;
  logic copi_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (1'(CPOL))
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (SCK),
    .cs       (CS),
    .copi     (COPI),
    .sck_lead (sck_lead),
    .sck_trail(sck_trail),
    .cs_active(cs_active),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .copi_s   (copi_s)
  );

  logic [CW-1:0] cnt;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] rx_pos;
  logic [CW-1:0] tx_pos;
  logic [W-1:0]  rx_shift;
  logic [W-1:0]  rx_next;
  logic [W-1:0]  tx_reg;
  logic          hold;
  logic          sample;
  logic          shift;
  logic          complete;
  logic          load;

  // Word bit position of the k-th bit on the wire.
  function automatic logic [CW-1:0] wire_pos(
    input logic [CW-1:0] k
  );
    int b;
    b = byte_index(int'(k) / 8,
                   LSB_BYTE_FIRST[0],
                   BYTES_PER_WORD);
    return CW'(8 * b + 7 - (int'(k) % 8));
  endfunction

  always_comb begin
    sample   = cs_active && !cs_rise &&
               (SAMPLE_TRAIL ? sck_trail : sck_lead);
    shift    = cs_active && !cs_rise &&
               (SAMPLE_TRAIL ? sck_lead : sck_trail);
    complete = sample && (cnt == CW'(W - 1));
    load     = cs_fall || complete;
    rx_pos   = wire_pos(cnt);
    tx_pos   = wire_pos(tcnt);
    rx_next  = rx_shift;
    rx_next[rx_pos] = copi_s;
  end

  assign tx_load = load && !reset;
  assign CIPO    = (cs_active && !reset) ?
                   tx_reg[tx_pos] : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rx_shift    <= '0;
      rx_word     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_abort <= 1'b0;
      tx_reg      <= '0;
      tcnt        <= '0;
      hold        <= 1'b0;
    end else begin
      frame_abort <= cs_rise && (cnt != '0);

      if (cs_rise) begin
        cnt <= '0;
      end else if (sample) begin
        cnt <= complete ? '0 : cnt + 1'b1;
      end

      if (sample) begin
        rx_shift <= rx_next;
      end

      // A same-cycle ack frees the slot before the new word lands.
      if (complete) begin
        if (!rx_valid || rx_ack) begin
          rx_word  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      // hold swallows the one shift edge that must not advance.
      if (load) begin
        tx_reg <= tx_word;
        tcnt   <= '0;
        hold   <= (CPHA != 0) || complete;
      end else if (shift) begin
        if (hold) begin
          hold <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_word_peripheral.sv
// Self-checking bench: mode 0 / 64-bit LSB-byte-first
// and mode 3 / 16-bit top-byte-first instances.
module tb_spi_word_peripheral;

  localparam int HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_sck, a_cs, a_copi, a_rx_ack;
  wire         a_cipo;
  logic [63:0] a_tx;
  wire  [63:0] a_rx;
  wire         a_tx_load, a_rx_valid, a_ovr, a_abort;

  logic        b_sck, b_cs, b_copi, b_rx_ack;
  wire         b_cipo;
  logic [15:0] b_tx;
  wire  [15:0] b_rx;
  wire         b_tx_load, b_rx_valid, b_ovr, b_abort;

  pullup (a_cipo);
  pullup (b_cipo);

  spi_word_peripheral dut_a (
    .clk        (clk),
    .reset      (reset),
    .SCK        (a_sck),
    .CS         (a_cs),
    .COPI       (a_copi),
    .CIPO       (a_cipo),
    .tx_word    (a_tx),
    .tx_load    (a_tx_load),
    .rx_word    (a_rx),
    .rx_valid   (a_rx_valid),
    .rx_ack     (a_rx_ack),
    .rx_overrun (a_ovr),
    .frame_abort(a_abort)
  );

  spi_word_peripheral #(
    .BYTES_PER_WORD(2),
    .CPOL          (1),
    .CPHA          (1),
    .LSB_BYTE_FIRST(0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .SCK        (b_sck),
    .CS         (b_cs),
    .COPI       (b_copi),
    .CIPO       (b_cipo),
    .tx_word    (b_tx),
    .tx_load    (b_tx_load),
    .rx_word    (b_rx),
    .rx_valid   (b_rx_valid),
    .rx_ack     (b_rx_ack),
    .rx_overrun (b_ovr),
    .frame_abort(b_abort)
  );

  int pass_cnt = 0;
  int total    = 0;
  int a_loads  = 0;
  int a_aborts = 0;
  int b_loads  = 0;
  int b_aborts = 0;
  int a_mid    = 0;

  always @(negedge clk) begin
    if (a_tx_load) a_loads++;
    if (a_abort)   a_aborts++;
    if (b_tx_load) b_loads++;
    if (b_abort)   b_aborts++;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  logic [63:0] a_txq [4];
  logic [63:0] a_cpq [4];
  logic [63:0] a_got [4];
  logic [7:0]  a_bytes [32];

  // Controller, mode 0: word bit for wire bit j is
  // byte j/8 (LSB byte first), bit 7-j%8 within it.
  task automatic a_frame(input int nw, input int nbits,
                         input int special,
                         input bit keep_cs);
    a_tx = a_txq[0];
    a_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      int w, j, p;
      w = k / 64;
      j = k % 64;
      p = 8 * (j / 8) + 7 - (j % 8);
      a_copi = a_cpq[w][p];
      repeat (HALF) @(negedge clk);
      a_got[w][p] = a_cipo;
      a_bytes[k / 8][7 - k % 8] = a_cipo;
      a_sck = 1'b1;
      if (k == 63) a_mid = a_loads;
      if (j == 63 && w + 1 < nw) a_tx = a_txq[w + 1];
      if (j == 63 && w == nw - 1 && special == 1) begin
        repeat (3) @(negedge clk);
        check("latency_edge+3", a_rx_valid, 0);
        @(negedge clk);
        check("latency_edge+4", a_rx_valid, 1);
        repeat (HALF - 4) @(negedge clk);
      end else if (j == 63 && w == nw - 1 && special == 2) begin
        repeat (3) @(negedge clk);
        a_rx_ack = 1'b1;
        @(negedge clk);
        a_rx_ack = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      a_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (!keep_cs) begin
      a_cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask

  // Controller, mode 3, 16-bit word sent MSB first.
  task automatic b_frame(input logic [15:0] cp,
                         input logic [15:0] tx,
                         output logic [15:0] got);
    b_tx = tx;
    b_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      b_copi = cp[15 - k];
      b_sck  = 1'b0;
      repeat (HALF) @(negedge clk);
      got[15 - k] = b_cipo;
      b_sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    b_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic a_ack();
    a_rx_ack = 1'b1;
    @(negedge clk);
    a_rx_ack = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] copi;
    logic [63:0] tx;
    logic [63:0] exp_rx;
    logic [63:0] exp_cipo;
  } vec_t;

  vec_t        tbl [4];
  logic [7:0]  exp2 [8];
  logic [15:0] bgot;
  logic [15:0] bcp, btx;
  int          base, abase, nw;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[1] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{64'h8000_0000_0000_0001,
               64'h0123_4567_89AB_CDEF,
               64'h8000_0000_0000_0001,
               64'h0123_4567_89AB_CDEF};
    tbl[3] = '{64'hDEAD_BEEF_CAFE_F00D,
               64'h00FF_00FF_A5A5_5A5A,
               64'hDEAD_BEEF_CAFE_F00D,
               64'h00FF_00FF_A5A5_5A5A};
    exp2 = '{8'hC3, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'hA5, 8'hA5};

    reset = 1'b1;
    a_sck = 1'b0; a_cs = 1'b1; a_copi = 1'b0;
    a_rx_ack = 1'b0; a_tx = 64'hFFFF_FFFF_FFFF_FFFF;
    b_sck = 1'b1; b_cs = 1'b1; b_copi = 1'b0;
    b_rx_ack = 1'b0; b_tx = 16'hFFFF;
    repeat (4) @(negedge clk);
    check("rst_rx_word", a_rx, 0);
    check("rst_rx_valid", a_rx_valid, 0);
    check("rst_overrun", a_ovr, 0);
    check("rst_tx_load", a_tx_load, 0);
    check("rst_abort", a_abort, 0);
    check("rst_cipo_released", a_cipo, 1);
    check("rst_b_rx_valid", b_rx_valid, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_cipo_released", a_cipo, 1);

    // single frame, latency
    a_cpq[0] = 64'h0123_4567_89AB_CDEF;
    a_txq[0] = {$urandom, $urandom};
    base = a_loads;
    a_frame(1, 64, 1, 1'b0);
    check("t1_rx_word", a_rx, 64'h0123_4567_89AB_CDEF);
    check("t1_rx_valid", a_rx_valid, 1);
    check("t1_overrun", a_ovr, 0);
    check("t1_cipo", a_got[0], a_txq[0]);
    check("t1_loads", a_loads - base, 2);
    a_ack();
    check("t1_ack_clears", a_rx_valid, 0);

    // byte order on the wire
    a_txq[0] = 64'hA5A5_0000_0000_00C3;
    a_cpq[0] = {$urandom, $urandom};
    base = a_loads;
    a_frame(1, 64, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_byte%0d", i), a_bytes[i], exp2[i]);
    check("t2_loads_in_word", a_mid - base, 1);
    check("t2_rx_word", a_rx, a_cpq[0]);
    a_ack();

    for (int i = 0; i < 4; i++) begin
      a_cpq[0] = tbl[i].copi;
      a_txq[0] = tbl[i].tx;
      a_frame(1, 64, 0, 1'b0);
      check($sformatf("tbl%0d_rx", i), a_rx, tbl[i].exp_rx);
      check($sformatf("tbl%0d_cipo", i),
            a_got[0], tbl[i].exp_cipo);
      a_ack();
    end

    // mode 3, 16-bit
    base = b_loads;
    b_frame(16'hBEEF, 16'h1234, bgot);
    check("t3_rx_word", b_rx, 16'hBEEF);
    check("t3_cipo", bgot, 16'h1234);
    check("t3_rx_valid", b_rx_valid, 1);
    check("t3_loads", b_loads - base, 2);
    b_rx_ack = 1'b1;
    @(negedge clk);
    b_rx_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bcp = 16'($urandom);
      btx = 16'($urandom);
      b_frame(bcp, btx, bgot);
      check("rnd_b_rx", b_rx, bcp);
      check("rnd_b_cipo", bgot, btx);
      check("rnd_b_ovr", b_ovr, 0);
      b_rx_ack = 1'b1;
      @(negedge clk);
      b_rx_ack = 1'b0;
    end
    check("b_no_abort", b_aborts, 0);

    // back-to-back, overrun
    a_cpq[0] = 64'h1111_1111_1111_1111;
    a_cpq[1] = 64'h2222_2222_2222_2222;
    a_txq[0] = {$urandom, $urandom};
    a_txq[1] = {$urandom, $urandom};
    a_frame(2, 128, 0, 1'b0);
    check("t4_rx_word", a_rx, 64'h1111_1111_1111_1111);
    check("t4_rx_valid", a_rx_valid, 1);
    check("t4_overrun", a_ovr, 1);
    check("t4_cipo_w1", a_got[1], a_txq[1]);
    a_ack();
    check("t4_ack_valid", a_rx_valid, 0);
    check("t4_ack_ovr", a_ovr, 0);

    // ack in the completion cycle
    a_cpq[0] = 64'h3333_3333_3333_3333;
    a_cpq[1] = 64'h4444_4444_4444_4444;
    a_frame(2, 128, 2, 1'b0);
    check("ackE_rx_word", a_rx, 64'h4444_4444_4444_4444);
    check("ackE_valid", a_rx_valid, 1);
    check("ackE_ovr", a_ovr, 0);
    a_ack();

    // random multi-word frames
    for (int it = 0; it < 5; it++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 3; w++) begin
        a_cpq[w] = {$urandom, $urandom};
        a_txq[w] = {$urandom, $urandom};
      end
      base = a_loads;
      a_frame(nw, 64 * nw, 0, 1'b0);
      check("rnd_rx", a_rx, a_cpq[0]);
      check("rnd_ovr", a_ovr, (nw > 1) ? 1 : 0);
      check("rnd_loads", a_loads - base, nw + 1);
      for (int w = 0; w < nw; w++)
        check($sformatf("rnd_cipo_w%0d", w), a_got[w], a_txq[w]);
      a_ack();
    end

    // aborted frame
    abase = a_aborts;
    a_cpq[0] = {$urandom, $urandom};
    a_frame(1, 13, 0, 1'b0);
    check("t5_abort", a_aborts - abase, 1);
    check("t5_valid", a_rx_valid, 0);
    a_cs = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    a_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("t5_empty_cs", a_aborts - abase, 1);
    a_cpq[0] = 64'h5555_5555_5555_5555;
    a_frame(1, 64, 0, 1'b0);
    check("t5_rx_word", a_rx, 64'h5555_5555_5555_5555);
    check("t5_valid2", a_rx_valid, 1);
    check("t5_abort2", a_aborts - abase, 1);

    // reset mid-frame
    a_cpq[0] = 64'hFEDC_BA98_7654_3210;
    a_txq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    a_frame(1, 30, 0, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_cipo", a_cipo, 1);
    check("t6_rx_word", a_rx, 0);
    check("t6_valid", a_rx_valid, 0);
    check("t6_ovr", a_ovr, 0);
    check("t6_tx_load", a_tx_load, 0);
    a_cs = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    abase = a_aborts;
    a_cpq[0] = 64'h0F1E_2D3C_4B5A_6978;
    a_txq[0] = {$urandom, $urandom};
    a_frame(1, 64, 0, 1'b0);
    check("t6_rx_after", a_rx, 64'h0F1E_2D3C_4B5A_6978);
    check("t6_cipo_after", a_got[0], a_txq[0]);
    check("t6_ovr_after", a_ovr, 0);
    check("t6_no_abort", a_aborts - abase, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
